// File: rtl/dct_pkg.sv
// Shared DCT definitions: transform size, cosine-term word type and the
// cosine-table sequencer state encoding.
package dct_pkg;

  localparam int DCT_N     = 8;
  localparam int DCT_IDX_W = 3;

  typedef logic [31:0] cos_term_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_RELEASE,
    ST_DONE,
    ST_ERR
  } cos_tbl_state_t;

endpackage

// File: rtl/cos_term_ram.sv
// 64-word cosine-term store: one synchronous write port, one registered read
// port; a same-address read and write in one cycle returns the old word.
module cos_term_ram
  import dct_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [2*DCT_IDX_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [2*DCT_IDX_W-1:0]   rd_addr,
  output logic [DATA_W-1:0]        rd_data_p1
);

  logic [DATA_W-1:0] mem [DCT_N*DCT_N];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data_p1 <= mem[rd_addr];
  end

endmodule

// File: rtl/cos_term_table.sv
// Sequences the cosine-term unit over all 64 (k1,k2) pairs, stores each
// returned term, and serves the DCT datapath through a registered read port.
module cos_term_table
  import dct_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int DATA_W         = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  build,
  output logic                  busy,
  output logic                  done,
  output logic                  table_valid,
  output logic                  error,
  output logic [DCT_IDX_W-1:0]  cos_k1,
  output logic [DCT_IDX_W-1:0]  cos_k2,
  output logic                  cos_start,
  input  logic                  cos_finish,
  input  logic [DATA_W-1:0]     cos_c_k1_k2,
  input  logic [5:0]            rd_addr,
  output logic [DATA_W-1:0]     rd_data
);

  localparam int IDX_W    = 2 * DCT_IDX_W;
  localparam int LAST_IDX = DCT_N * DCT_N - 1;
  localparam int CNT_W    = $clog2(TIMEOUT_CYCLES + 1);

  cos_tbl_state_t state, next_state;

  logic [IDX_W-1:0]  idx;
  logic [CNT_W-1:0]  cnt;
  logic              timeout;
  logic              last_idx;
  logic              ram_we;
  logic              vld_p1;
  logic [DATA_W-1:0] ram_q_p1;

  assign timeout  = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign last_idx = (idx == IDX_W'(LAST_IDX));
  assign cos_k1   = idx[IDX_W-1:DCT_IDX_W];
  assign cos_k2   = idx[DCT_IDX_W-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // A returned term wins over a timeout expiring in the same cycle.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (build) next_state = ST_REQ;
      end
      ST_REQ: begin
        if (cos_finish)   next_state = ST_RELEASE;
        else if (timeout) next_state = ST_ERR;
      end
      ST_RELEASE: begin
        if (!cos_finish)  next_state = last_idx ? ST_DONE : ST_REQ;
        else if (timeout) next_state = ST_ERR;
      end
      ST_DONE: next_state = ST_IDLE;
      ST_ERR:  next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    cos_start = (state == ST_REQ);
    busy      = (state == ST_REQ) || (state == ST_RELEASE);
    done      = (state == ST_DONE) || (state == ST_ERR);
    ram_we    = (state == ST_REQ) && cos_finish;
  end

  // The wait counter restarts on every state change, so it only ever measures
  // the time spent in the current REQ or RELEASE visit.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx         <= '0;
      cnt         <= '0;
      table_valid <= 1'b0;
      error       <= 1'b0;
      vld_p1      <= 1'b0;
    end else begin
      vld_p1 <= 1'b1;
      if (next_state != state) begin
        cnt <= '0;
      end else if (busy) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (state == ST_IDLE && build) begin
        idx         <= '0;
        table_valid <= 1'b0;
        error       <= 1'b0;
      end
      if (state == ST_RELEASE && !cos_finish && !last_idx) begin
        idx <= idx + IDX_W'(1);
      end
      if (state == ST_RELEASE && next_state == ST_DONE) begin
        table_valid <= 1'b1;
      end
      if (next_state == ST_ERR) begin
        error <= 1'b1;
      end
    end
  end

  cos_term_ram #(
    .DATA_W (DATA_W)
  ) u_ram (
    .clk        (clk),
    .we         (ram_we),
    .wr_addr    (idx),
    .wr_data    (cos_c_k1_k2),
    .rd_addr    (rd_addr),
    .rd_data_p1 (ram_q_p1)
  );

  // Read stage p1: the storage itself has no reset, so the word is forced to
  // zero until the first post-reset read has been captured.
  assign rd_data = vld_p1 ? ram_q_p1 : '0;

endmodule

// File: tb/tb_cos_term_table.sv
// Directed bench for cos_term_table with a behavioural cosine-unit responder
// and a handshake monitor.
module tb_cos_term_table;

  logic        clk = 1'b0;
  logic        reset;
  logic        build;
  logic        busy, done, table_valid, error;
  logic [2:0]  cos_k1, cos_k2;
  logic        cos_start;
  logic        cos_finish;
  logic [31:0] cos_c_k1_k2;
  logic [5:0]  rd_addr;
  logic [31:0] rd_data;

  always #5 clk = ~clk;

  cos_term_table #(
    .TIMEOUT_CYCLES (16),
    .DATA_W         (32)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .build       (build),
    .busy        (busy),
    .done        (done),
    .table_valid (table_valid),
    .error       (error),
    .cos_k1      (cos_k1),
    .cos_k2      (cos_k2),
    .cos_start   (cos_start),
    .cos_finish  (cos_finish),
    .cos_c_k1_k2 (cos_c_k1_k2),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data)
  );

  // Responder knobs, set by the test sequence
  int          fin_delay = 3;
  int          rel_hold  = 0;
  int          hang_idx  = -1;
  logic [31:0] base      = 32'hC0DE_0000;
  int          m_cnt, r_cnt;

  always @(posedge clk) begin
    if (reset) begin
      cos_finish <= 1'b0;
      m_cnt      <= 0;
      r_cnt      <= 0;
    end else if (!cos_finish) begin
      if (cos_start && int'({cos_k1, cos_k2}) != hang_idx) begin
        if (m_cnt + 1 >= fin_delay) begin
          cos_finish  <= 1'b1;
          cos_c_k1_k2 <= base | {26'd0, cos_k1, cos_k2};
          m_cnt       <= 0;
        end else begin
          m_cnt <= m_cnt + 1;
        end
      end
    end else if (!cos_start) begin
      if (r_cnt >= rel_hold) begin
        cos_finish <= 1'b0;
        r_cnt      <= 0;
      end else begin
        r_cnt <= r_cnt + 1;
      end
    end
  end

  // Handshake monitor
  logic       mon_clr;
  int         req_cnt, order_err, early_err, stable_err, done_cnt, run, max_run;
  logic       p_start, p_finish;
  logic [5:0] p_k;

  always @(negedge clk) begin
    if (mon_clr) begin
      req_cnt <= 0; order_err <= 0; early_err <= 0; stable_err <= 0;
      done_cnt <= 0; run <= 0; max_run <= 0;
    end else begin
      if (cos_start && !p_start) begin
        if ({cos_k1, cos_k2} != req_cnt[5:0]) order_err <= order_err + 1;
        if (p_finish) early_err <= early_err + 1;
        req_cnt <= req_cnt + 1;
      end
      if (cos_start && p_start && {cos_k1, cos_k2} != p_k) stable_err <= stable_err + 1;
      if (done) done_cnt <= done_cnt + 1;
      if (cos_start) begin
        run <= run + 1;
        if (run + 1 > max_run) max_run <= run + 1;
      end else begin
        run <= 0;
      end
    end
    p_start  <= cos_start;
    p_finish <= cos_finish;
    p_k      <= {cos_k1, cos_k2};
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_build();
    build = 1'b1;
    tick();
    build = 1'b0;
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    tick();
    mon_clr = 1'b0;
  endtask

  task automatic read_word(input logic [5:0] a, output logic [31:0] d);
    rd_addr = a;
    tick();
    d = rd_data;
  endtask

  // Waits for the done pulse and snapshots the status outputs in that cycle.
  task automatic wait_done(input int budget, output logic seen, output logic tv,
                           output logic bsy, output logic st, output logic er);
    seen = 1'b0; tv = 1'bx; bsy = 1'bx; st = 1'bx; er = 1'bx;
    for (int i = 0; i < budget; i++) begin
      if (done) begin
        seen = 1'b1; tv = table_valid; bsy = busy; st = cos_start; er = error;
        break;
      end
      tick();
    end
  endtask

  typedef struct {
    logic [5:0]  addr;
    logic [31:0] exp;
  } rd_vec_t;

  rd_vec_t vecs[8];

  logic        seen, tv, bsy, st, er;
  logic [31:0] d;

  initial begin
    vecs[0] = '{6'o00, 32'hC0DE_0000};
    vecs[1] = '{6'o01, 32'hC0DE_0001};
    vecs[2] = '{6'o07, 32'hC0DE_0007};
    vecs[3] = '{6'o10, 32'hC0DE_0008};
    vecs[4] = '{6'o25, 32'hC0DE_0015};
    vecs[5] = '{6'o52, 32'hC0DE_002A};
    vecs[6] = '{6'o70, 32'hC0DE_0038};
    vecs[7] = '{6'o77, 32'hC0DE_003F};

    reset = 1'b1; build = 1'b0; rd_addr = 6'd0; mon_clr = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    mon_clr = 1'b0;

    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_table_valid", {31'd0, table_valid}, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    chk("rst_cos_start", {31'd0, cos_start}, 32'd0);
    chk("rst_k1k2", {26'd0, cos_k1, cos_k2}, 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);

    // Full build with a stray build pulse while busy
    clear_mon();
    pulse_build();
    chk("start_after_build", {31'd0, cos_start}, 32'd1);
    chk("busy_after_build", {31'd0, busy}, 32'd1);
    repeat (10) tick();
    pulse_build();
    wait_done(2000, seen, tv, bsy, st, er);
    chk("b1_done_seen", {31'd0, seen}, 32'd1);
    chk("b1_tv_at_done", {31'd0, tv}, 32'd1);
    chk("b1_busy_at_done", {31'd0, bsy}, 32'd0);
    chk("b1_err_at_done", {31'd0, er}, 32'd0);
    repeat (4) tick();
    chk("b1_done_count", done_cnt, 32'd1);
    chk("b1_req_count", req_cnt, 32'd64);
    chk("b1_order_err", order_err, 32'd0);
    chk("b1_stable_err", stable_err, 32'd0);
    chk("b1_early_start", early_err, 32'd0);
    chk("b1_tv_hold", {31'd0, table_valid}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      read_word(vecs[i].addr, d);
      chk($sformatf("b1_rd_%0o", vecs[i].addr), d, vecs[i].exp);
    end

    // Slow release: finish lingers 5 cycles after start falls
    rel_hold = 5;
    base = 32'hBEEF_0000;
    clear_mon();
    pulse_build();
    chk("sr_tv_cleared", {31'd0, table_valid}, 32'd0);
    wait_done(3000, seen, tv, bsy, st, er);
    chk("sr_done_seen", {31'd0, seen}, 32'd1);
    chk("sr_tv_at_done", {31'd0, tv}, 32'd1);
    repeat (2) tick();
    chk("sr_req_count", req_cnt, 32'd64);
    chk("sr_early_start", early_err, 32'd0);
    chk("sr_order_err", order_err, 32'd0);
    read_word(6'o70, d);
    chk("sr_rd_70", d, 32'hBEEF_0038);
    read_word(6'o13, d);
    chk("sr_rd_13", d, 32'hBEEF_000B);
    rel_hold = 0;

    // Timeout: responder never answers index 10
    hang_idx = 10;
    base = 32'h1234_0000;
    clear_mon();
    pulse_build();
    wait_done(2000, seen, tv, bsy, st, er);
    chk("to_done_seen", {31'd0, seen}, 32'd1);
    chk("to_err_at_done", {31'd0, er}, 32'd1);
    chk("to_busy_at_done", {31'd0, bsy}, 32'd0);
    chk("to_tv_at_done", {31'd0, tv}, 32'd0);
    chk("to_start_at_done", {31'd0, st}, 32'd0);
    repeat (3) tick();
    chk("to_req_count", req_cnt, 32'd11);
    chk("to_start_run", max_run, 32'd16);
    chk("to_err_sticky", {31'd0, error}, 32'd1);
    chk("to_done_count", done_cnt, 32'd1);

    hang_idx = -1;
    clear_mon();
    pulse_build();
    chk("to_err_cleared", {31'd0, error}, 32'd0);
    wait_done(2000, seen, tv, bsy, st, er);
    chk("to_rebuild_done", {31'd0, seen}, 32'd1);
    chk("to_rebuild_tv", {31'd0, tv}, 32'd1);
    chk("to_rebuild_err", {31'd0, er}, 32'd0);
    tick();
    read_word(6'o12, d);
    chk("to_rd_12", d, 32'h1234_000A);

    // Reset while the request for index 20 is outstanding
    base = 32'h5A5A_0000;
    clear_mon();
    pulse_build();
    for (int i = 0; i < 1000 && req_cnt < 21; i++) tick();
    chk("mr_reached_idx20", req_cnt, 32'd21);
    reset = 1'b1;
    tick();
    chk("mr_start", {31'd0, cos_start}, 32'd0);
    chk("mr_busy", {31'd0, busy}, 32'd0);
    chk("mr_tv", {31'd0, table_valid}, 32'd0);
    reset = 1'b0;
    tick();
    base = 32'h0F0F_0000;
    clear_mon();
    pulse_build();
    wait_done(2000, seen, tv, bsy, st, er);
    chk("mr_rebuild_done", {31'd0, seen}, 32'd1);
    chk("mr_rebuild_tv", {31'd0, tv}, 32'd1);
    repeat (2) tick();
    chk("mr_req_count", req_cnt, 32'd64);
    chk("mr_order_err", order_err, 32'd0);
    read_word(6'o24, d);
    chk("mr_rd_24", d, 32'h0F0F_0014);
    read_word(6'o77, d);
    chk("mr_rd_77", d, 32'h0F0F_003F);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cos_term_table.md
# cos_term_table

Builds and holds the full 8x8 table of DCT cosine terms by sequencing the `compute_cos_terms` unit over all 64 (k1, k2) pairs. It acts as the initiator on the cos-term start/finish handshake and stores each returned `c_k1_k2` word in a 64-entry register file. The DCT datapath then reads terms from that file through a registered read port instead of recomputing them. It sits between `compute_cos_terms` and the DCT multiply-accumulate stage.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 4096: maximum cycles to wait for `cos_finish` after asserting `cos_start`.
- `DATA_W`, 32: width of a cosine term; must match `c_k1_k2`.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `build`  in  1  one-cycle pulse that starts a table build.
- `busy`  out  1  high while a build is in progress.
- `done`  out  1  one-cycle pulse when a build finishes (success or error).
- `table_valid`  out  1  high after a successful build; cleared by reset, by `build`, or by an error.
- `error`  out  1  sticky timeout flag; cleared by reset or the next accepted `build`.
- `cos_k1`  out  3  k1 index presented to the cos unit.
- `cos_k2`  out  3  k2 index presented to the cos unit.
- `cos_start`  out  1  request to the cos unit.
- `cos_finish`  in  1  response from the cos unit.
- `cos_c_k1_k2`  in  DATA_W  term returned by the cos unit.
- `rd_addr`  in  6  read address, `{k1,k2}`.
- `rd_data`  out  DATA_W  registered read data.

## Operation
- States:
  - IDLE: wait for `build`.
  - REQ: `cos_start`=1; wait for `cos_finish`.
  - RELEASE: `cos_start`=0; wait for `cos_finish`=0.
  - DONE: one cycle; pulse `done`.
  - ERR: one cycle; pulse `done`, set `error`.
- IDLE→REQ on `build`:
  - Clear the index to 0, clear `table_valid` and `error`, set `busy`.
- Index order and addressing:
  - 6-bit index `idx`; `cos_k1`=`idx[5:3]`, `cos_k2`=`idx[2:0]`.
  - k1 is the outer loop, k2 the inner; word address = `idx`.
- REQ:
  - Hold `cos_start` high and the indices stable until `cos_finish` is sampled high.
  - On that cycle, write `cos_c_k1_k2` to `mem[idx]` and go to RELEASE.
- RELEASE:
  - Hold the indices.
  - When `cos_finish` is sampled low: if `idx`==63 go to DONE; otherwise increment `idx` and go to REQ.
- DONE:
  - `busy`=0, `table_valid`=1, go to IDLE.
- Timeout:
  - A cycle counter is cleared on entry to REQ and to RELEASE.
  - If it reaches `TIMEOUT_CYCLES` in either state, go to ERR: `cos_start`=0, `busy`=0, `error`=1, `table_valid` stays 0, then go to IDLE.
- Read port:
  - `rd_data` <= `mem[rd_addr]` every cycle, regardless of state.
  - Reads during a build return partially written contents; consumers gate on `table_valid`.
- `build` while `busy` is ignored; the build in progress is not restarted.

## Timing
- Reset values:
  - State=IDLE; `busy`, `done`, `table_valid`, `error`, `cos_start`=0; `cos_k1`, `cos_k2`=0; `rd_data`=0.
  - `mem` is not reset.
- `cos_start` rises on the cycle after `build` is sampled.
- Per term: 1 cycle of REQ minimum, plus the responder's latency, plus at least 1 cycle of RELEASE.
- `cos_start` is always low for at least one cycle between consecutive requests.
- `done` is asserted in the cycle after the last RELEASE exit. `table_valid` and the `busy` fall both take effect in that same cycle.
- Read latency is 1 cycle.
- A write and a read to the same address in the same cycle return the old data.
- Reset mid-build: the next cycle has `cos_start`=0, state IDLE, and `table_valid`=0. The cos unit must also be reset by the same `reset`.
- If `cos_finish` is already high on REQ entry, capture occurs in that first REQ cycle.

## Structure
- Shared package `dct_pkg`:
  - `DCT_N`=8 and `DCT_IDX_W`=3.
  - The `cos_term_t` typedef (logic [31:0]).
  - The state enum `cos_tbl_state_t`.
- Sub-module `cos_term_ram`: 64×DATA_W, one synchronous write port and one registered read port. It contains no reset logic.

## Test plan
- Full build: the mock cos unit raises finish 3 cycles after start and returns `32'hC0DE_0000 | idx`. Required: `done` pulses once, `table_valid`=1, and reading `rd_addr`=6'o70 (k1=7, k2=0) returns `32'hC0DE_0038` one cycle later.
- Handshake ordering: capture (k1, k2, start) over a whole build. Required: 64 requests in order (0,0),(0,1)…(7,7), and start is low for ≥1 cycle between requests.
- Slow release: the mock holds finish high 5 cycles after start falls. Required: the next start does not rise until finish has been low for 1 cycle, and the data is still correct.
- Timeout: with `TIMEOUT_CYCLES`=16, the mock never raises finish at idx 10. Required: `error`=1, `done` pulses, `busy`=0, `table_valid`=0, and `cos_start`=0 by cycle 17 of REQ. A subsequent `build` clears `error` and completes.
- Reset mid-build: assert `reset` at idx 20. Required: the next cycle has `cos_start`=0, `busy`=0, `table_valid`=0. A fresh build then completes correctly.
- `build` pulsed while `busy`: required to have no effect; exactly 64 requests and one `done` pulse.
